tx_port_writer: RTL and testbench
=================================

TX_PORT_WRITER -- requirements
Module: tx_port_writer

Interface
REQ-001 SHALL have parameter C_AVAIL_WIDTH, default 16, width of DATA_AVAIL in 32-bit words.
REQ-002 SHALL have port CLK in 1, the single clock; all logic on rising edge.
REQ-003 SHALL have port RST in 1, synchronous active-high reset.
REQ-004 SHALL have port CONFIG_MAX_PAYLOAD_SIZE in 3: 000=128B, 001=256B, 010=512B, 011 and above=1024B.
REQ-005 SHALL have port BUF_VALID in 1, a scatter-gather buffer descriptor is presented.
REQ-006 SHALL have port BUF_ADDR in 64, buffer byte address; bits [1:0] are forced to 0.
REQ-007 SHALL have port BUF_LEN in 32, buffer length in 32-bit words.
REQ-008 SHALL have port BUF_ACK out 1, a one-cycle pulse meaning the descriptor is latched.
REQ-009 SHALL have port DATA_AVAIL in C_AVAIL_WIDTH, words currently held in the outgoing data FIFO.
REQ-010 SHALL have port ABORT in 1, which stops issuing further requests.
REQ-011 SHALL have port TX_REQ out 1, a write request.
REQ-012 SHALL have port TX_REQ_ACK in 1, request accepted by the TX engine.
REQ-013 SHALL have port TX_ADDR out 64, request byte address.
REQ-014 SHALL have port TX_LEN out 10, request length in words.
REQ-015 SHALL have port TX_SENT in 1, a one-cycle pulse meaning the accepted request has been fully transmitted.
REQ-016 SHALL have port BUF_DONE out 1, a one-cycle pulse meaning the buffer is complete.
REQ-017 SHALL have port BUF_DONE_LEN out 32, words actually sent; valid while BUF_DONE is high.
REQ-018 SHALL have port IDLE out 1, high only in state IDLE.

Function
REQ-019 SHALL implement states IDLE, CALC, REQ, WAIT and DONE; all outputs are registered.
REQ-020 IDLE: when BUF_VALID is sampled high, SHALL latch the address and length, pulse BUF_ACK in the next cycle, and go to CALC (or to DONE if BUF_LEN=0); BUF_VALID outside IDLE SHALL be ignored.
REQ-021 CALC: SHALL compute len = min(remaining, MPS words [32/64/128/256], words to the next 4KB boundary = (4096-addr[11:0])>>2).
REQ-022 CALC: SHALL go to REQ only when DATA_AVAIL >= len, otherwise stay in CALC; if ABORT is high, SHALL go to DONE instead.
REQ-023 REQ: TX_REQ SHALL be high, with TX_ADDR and TX_LEN held stable, until TX_REQ_ACK is sampled high; TX_REQ SHALL then drop the next cycle and the state SHALL become WAIT.
REQ-024 Once TX_REQ is asserted it SHALL NOT be withdrawn before TX_REQ_ACK; ABORT during REQ SHALL only be recorded.
REQ-025 WAIT: on TX_SENT, SHALL apply addr += len*4, remaining -= len and done_len += len, then go to DONE if remaining=0 or an abort is recorded, else to CALC.
REQ-026 TX_SENT outside WAIT SHALL be ignored; at most one request SHALL be outstanding.
REQ-027 DONE: BUF_DONE=1 and BUF_DONE_LEN=done_len for one cycle, then IDLE; the abort record SHALL be cleared.
REQ-028 Latency: the first TX_REQ SHALL be high 2 cycles after BUF_VALID is sampled; the next TX_REQ SHALL follow 2 cycles after TX_SENT; BUF_DONE SHALL follow 1 cycle after the final TX_SENT.
REQ-029 Address arithmetic SHALL be 64-bit unsigned, carrying across bit 32; remaining and done_len SHALL be 32-bit and never underflow, since len <= remaining.
REQ-030 Boundaries: a request SHALL never cross a 4KB boundary; an address exactly on a 4KB boundary SHALL allow the full MPS; a buffer of length 0 SHALL produce no TX_REQ.
REQ-031 If TX_REQ_ACK and ABORT are both high in REQ, the request SHALL complete and the next state after TX_SENT SHALL be DONE.

Reset
REQ-032 RST SHALL force IDLE, with TX_REQ, BUF_ACK and BUF_DONE at 0, TX_ADDR, TX_LEN and BUF_DONE_LEN at 0, IDLE at 1, and internal counters and the abort record cleared.
REQ-033 RST mid-transfer SHALL abandon the buffer silently (no BUF_DONE); a TX_SENT arriving after reset SHALL be ignored.

Verification
REQ-034 MPS=000, addr 0x1000, len 100, DATA_AVAIL=1000, immediate ack/sent -> requests (0x1000,32), (0x1080,32), (0x1100,32), (0x1180,4); BUF_DONE_LEN=100.
REQ-035 MPS=001, addr 0x0FF0, len 64 -> requests (0x0FF0,4) then (0x1000,60); BUF_DONE_LEN=64.
REQ-036 MPS=000, len 20, DATA_AVAIL=10 -> no TX_REQ; raise DATA_AVAIL to 20 -> TX_REQ 1 cycle later with len 20.
REQ-037 MPS=000, len 100, ABORT asserted during the second REQ -> second request completes, no third; BUF_DONE_LEN=64.
REQ-038 BUF_LEN=0 -> BUF_ACK then BUF_DONE with BUF_DONE_LEN=0, and TX_REQ never asserted.
REQ-039 RST asserted in WAIT, then TX_SENT pulsed -> all outputs at reset values, IDLE=1, no BUF_DONE.

Source files
------------

// File: rtl/tx_port_writer.sv
// tx_port_writer: splits one scatter-gather buffer into a sequence of PCIe
// write requests. Each request is limited by the remaining length, the
// max payload size and the next 4KB boundary, and is only issued once the
// outgoing data FIFO holds enough words for it. Exactly one request is in
// flight at a time; the buffer is closed with a BUF_DONE pulse.
module tx_port_writer #(
  parameter int C_AVAIL_WIDTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [2:0]               CONFIG_MAX_PAYLOAD_SIZE,
  input  logic                     BUF_VALID,
  input  logic [63:0]              BUF_ADDR,
  input  logic [31:0]              BUF_LEN,
  output logic                     BUF_ACK,
  input  logic [C_AVAIL_WIDTH-1:0] DATA_AVAIL,
  input  logic                     ABORT,
  output logic                     TX_REQ,
  input  logic                     TX_REQ_ACK,
  output logic [63:0]              TX_ADDR,
  output logic [9:0]               TX_LEN,
  input  logic                     TX_SENT,
  output logic                     BUF_DONE,
  output logic [31:0]              BUF_DONE_LEN,
  output logic                     IDLE
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [63:0] addr_reg, addr_next;
  logic [31:0] remain_reg, remain_next;
  logic [31:0] done_len_reg, done_len_next;
  logic [9:0]  len_reg, len_next;
  logic        abort_reg, abort_next;
  logic        tx_req_reg, tx_req_next;
  logic [63:0] tx_addr_reg, tx_addr_next;
  logic [9:0]  tx_len_reg, tx_len_next;
  logic        buf_ack_reg, buf_ack_next;
  logic        buf_done_reg, buf_done_next;
  logic [31:0] buf_done_len_reg, buf_done_len_next;
  logic        idle_reg, idle_next;

  logic [31:0] mps_words;
  logic [12:0] bnd_bytes;
  logic [31:0] bnd_words;
  logic [31:0] min_rem_mps;
  logic [31:0] calc_len;
  logic [63:0] avail_ext;
  logic        avail_ok;

  // Request sizing: min(remaining, MPS, words left before the 4KB boundary).
  always_comb begin
    case (CONFIG_MAX_PAYLOAD_SIZE)
      3'b000:  mps_words = 32'd32;
      3'b001:  mps_words = 32'd64;
      3'b010:  mps_words = 32'd128;
      default: mps_words = 32'd256;
    endcase
    // An aligned address yields 4096 bytes, i.e. 1024 words, never limiting.
    bnd_bytes   = 13'd4096 - {1'b0, addr_reg[11:0]};
    bnd_words   = {21'd0, bnd_bytes[12:2]};
    min_rem_mps = (remain_reg < mps_words) ? remain_reg : mps_words;
    calc_len    = (min_rem_mps < bnd_words) ? min_rem_mps : bnd_words;
    avail_ext   = 64'(DATA_AVAIL);
    avail_ok    = (avail_ext >= {32'd0, calc_len});
  end

  // Next-state and next-output logic; every output is a registered value.
  always_comb begin
    state_next        = state_reg;
    addr_next         = addr_reg;
    remain_next       = remain_reg;
    done_len_next     = done_len_reg;
    len_next          = len_reg;
    abort_next        = abort_reg;
    tx_req_next       = tx_req_reg;
    tx_addr_next      = tx_addr_reg;
    tx_len_next       = tx_len_reg;
    buf_ack_next      = 1'b0;
    buf_done_next     = 1'b0;
    buf_done_len_next = buf_done_len_reg;

    case (state_reg)
      ST_IDLE: begin
        if (BUF_VALID) begin
          addr_next     = {BUF_ADDR[63:2], 2'b00};
          remain_next   = BUF_LEN;
          done_len_next = 32'd0;
          abort_next    = 1'b0;
          buf_ack_next  = 1'b1;
          state_next    = (BUF_LEN == 32'd0) ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (ABORT) begin
          state_next = ST_DONE;
        end else if (avail_ok) begin
          len_next     = calc_len[9:0];
          tx_req_next  = 1'b1;
          tx_addr_next = addr_reg;
          tx_len_next  = calc_len[9:0];
          state_next   = ST_REQ;
        end
      end
      ST_REQ: begin
        // A posted request is never withdrawn; an abort only takes effect later.
        if (ABORT) begin
          abort_next = 1'b1;
        end
        if (TX_REQ_ACK) begin
          tx_req_next = 1'b0;
          state_next  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ABORT) begin
          abort_next = 1'b1;
        end
        if (TX_SENT) begin
          addr_next     = addr_reg + {52'd0, len_reg, 2'b00};
          remain_next   = remain_reg - {22'd0, len_reg};
          done_len_next = done_len_reg + {22'd0, len_reg};
          if ((remain_reg == {22'd0, len_reg}) || abort_reg || ABORT) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_CALC;
          end
        end
      end
      ST_DONE: begin
        abort_next = 1'b0;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (state_next == ST_DONE) begin
      buf_done_next     = 1'b1;
      buf_done_len_next = done_len_next;
    end
    idle_next = (state_next == ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg        <= ST_IDLE;
      addr_reg         <= 64'd0;
      remain_reg       <= 32'd0;
      done_len_reg     <= 32'd0;
      len_reg          <= 10'd0;
      abort_reg        <= 1'b0;
      tx_req_reg       <= 1'b0;
      tx_addr_reg      <= 64'd0;
      tx_len_reg       <= 10'd0;
      buf_ack_reg      <= 1'b0;
      buf_done_reg     <= 1'b0;
      buf_done_len_reg <= 32'd0;
      idle_reg         <= 1'b1;
    end else begin
      state_reg        <= state_next;
      addr_reg         <= addr_next;
      remain_reg       <= remain_next;
      done_len_reg     <= done_len_next;
      len_reg          <= len_next;
      abort_reg        <= abort_next;
      tx_req_reg       <= tx_req_next;
      tx_addr_reg      <= tx_addr_next;
      tx_len_reg       <= tx_len_next;
      buf_ack_reg      <= buf_ack_next;
      buf_done_reg     <= buf_done_next;
      buf_done_len_reg <= buf_done_len_next;
      idle_reg         <= idle_next;
    end
  end

  assign BUF_ACK      = buf_ack_reg;
  assign TX_REQ       = tx_req_reg;
  assign TX_ADDR      = tx_addr_reg;
  assign TX_LEN       = tx_len_reg;
  assign BUF_DONE     = buf_done_reg;
  assign BUF_DONE_LEN = buf_done_len_reg;
  assign IDLE         = idle_reg;

endmodule

// File: tb/tb_tx_port_writer.sv
// Bench for tx_port_writer: directed buffers from the requirement examples
// plus randomized buffers, each checked against a request list computed
// from the splitting rules with plain arithmetic.
module tb_tx_port_writer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [2:0]  CONFIG_MAX_PAYLOAD_SIZE = 3'd0;
  logic        BUF_VALID = 1'b0;
  logic [63:0] BUF_ADDR = 64'd0;
  logic [31:0] BUF_LEN = 32'd0;
  logic        BUF_ACK;
  logic [15:0] DATA_AVAIL = 16'd0;
  logic        ABORT = 1'b0;
  logic        TX_REQ;
  logic        TX_REQ_ACK = 1'b0;
  logic [63:0] TX_ADDR;
  logic [9:0]  TX_LEN;
  logic        TX_SENT = 1'b0;
  logic        BUF_DONE;
  logic [31:0] BUF_DONE_LEN;
  logic        IDLE;

  int cmp_count = 0;
  int err_count = 0;

  tx_port_writer #(.C_AVAIL_WIDTH(16)) dut (
    .CLK                    (CLK),
    .RST                    (RST),
    .CONFIG_MAX_PAYLOAD_SIZE(CONFIG_MAX_PAYLOAD_SIZE),
    .BUF_VALID              (BUF_VALID),
    .BUF_ADDR               (BUF_ADDR),
    .BUF_LEN                (BUF_LEN),
    .BUF_ACK                (BUF_ACK),
    .DATA_AVAIL             (DATA_AVAIL),
    .ABORT                  (ABORT),
    .TX_REQ                 (TX_REQ),
    .TX_REQ_ACK             (TX_REQ_ACK),
    .TX_ADDR                (TX_ADDR),
    .TX_LEN                 (TX_LEN),
    .TX_SENT                (TX_SENT),
    .BUF_DONE               (BUF_DONE),
    .BUF_DONE_LEN           (BUF_DONE_LEN),
    .IDLE                   (IDLE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_count++;
    assert (obs === exp) else begin
      err_count++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one buffer and follow it to BUF_DONE. abort_req is the request
  // index during which ABORT is raised (-1 for none); starve holds the FIFO
  // below the request size for a few cycles before each request.
  task automatic run_buffer(input logic [2:0] mps, input logic [63:0] addr,
                            input logic [31:0] len, input int abort_req,
                            input bit starve, input bit rnd);
    logic [63:0] qa[$];
    int          ql[$];
    logic [63:0] a;
    longint      rem;
    longint      mw;
    longint      l;
    longint      b;
    longint      done;
    int          n;
    int          d;
    // Reference split computed directly from the sizing rules.
    a   = {addr[63:2], 2'b00};
    rem = longint'(len);
    mw  = (mps >= 3'd3) ? 256 : (32 << mps);
    while (rem > 0) begin
      l = rem;
      if (l > mw) l = mw;
      b = (4096 - longint'(a % 64'd4096)) / 4;
      if (l > b) l = b;
      qa.push_back(a);
      ql.push_back(int'(l));
      a   = a + 64'(l * 4);
      rem = rem - l;
    end
    n = ql.size();
    if (abort_req >= 0 && abort_req < n) n = abort_req + 1;
    done = 0;
    for (int i = 0; i < n; i++) done += ql[i];

    CONFIG_MAX_PAYLOAD_SIZE = mps;
    BUF_ADDR   = addr;
    BUF_LEN    = len;
    BUF_VALID  = 1'b1;
    DATA_AVAIL = starve ? 16'(ql[0] / 2) : 16'hFFFF;
    step();
    BUF_VALID = 1'b0;
    BUF_ADDR  = {$urandom, $urandom};
    BUF_LEN   = $urandom;
    check("buf_ack", BUF_ACK, 1);

    for (int i = 0; i < n; i++) begin
      if (starve) begin
        step();
        step();
        step();
        check("starved_no_req", TX_REQ, 0);
        DATA_AVAIL = 16'(ql[i]);
        step();
        check("req_after_avail", TX_REQ, 1);
      end else begin
        step();
        check("req_latency", TX_REQ, 1);
      end
      check("tx_addr", TX_ADDR, qa[i]);
      check("tx_len", TX_LEN, 64'(ql[i]));
      $display("req %0d: addr=0x%0h len=%0d (expected 0x%0h/%0d)", i, TX_ADDR, TX_LEN, qa[i], ql[i]);

      ABORT = (i == abort_req);
      d = rnd ? int'($urandom_range(0, 3)) : 0;
      for (int k = 0; k < d; k++) begin
        BUF_VALID = 1'($urandom);
        TX_SENT   = 1'($urandom);
        step();
        check("req_hold", TX_REQ, 1);
        check("req_addr_stable", TX_ADDR, qa[i]);
        check("no_ack_outside_idle", BUF_ACK, 0);
      end
      BUF_VALID  = 1'b0;
      TX_SENT    = 1'b0;
      TX_REQ_ACK = 1'b1;
      step();
      TX_REQ_ACK = 1'b0;
      ABORT      = 1'b0;
      check("req_drop", TX_REQ, 0);

      d = rnd ? int'($urandom_range(0, 3)) : 0;
      for (int k = 0; k < d; k++) begin
        step();
        check("single_outstanding", TX_REQ, 0);
      end
      if (i + 1 < n) DATA_AVAIL = starve ? 16'(ql[i+1] / 2) : 16'hFFFF;
      TX_SENT = 1'b1;
      step();
      TX_SENT = 1'b0;
      if (i == n - 1) begin
        check("buf_done", BUF_DONE, 1);
        check("buf_done_len", BUF_DONE_LEN, 64'(done));
        check("no_req_after_last", TX_REQ, 0);
        $display("buffer done: len=%0d (expected %0d)", BUF_DONE_LEN, done);
        step();
        check("idle_after_done", IDLE, 1);
        check("done_pulse_one", BUF_DONE, 0);
      end else begin
        check("no_early_done", BUF_DONE, 0);
      end
    end
  endtask

  initial begin
    logic [63:0] ra;
    logic [31:0] rl;

    RST = 1'b1;
    step();
    step();
    check("rst_tx_req", TX_REQ, 0);
    check("rst_buf_ack", BUF_ACK, 0);
    check("rst_buf_done", BUF_DONE, 0);
    check("rst_tx_addr", TX_ADDR, 0);
    check("rst_tx_len", TX_LEN, 0);
    check("rst_done_len", BUF_DONE_LEN, 0);
    check("rst_idle", IDLE, 1);
    $display("reset: idle=%0d tx_req=%0d", IDLE, TX_REQ);
    RST = 1'b0;
    step();

    // 128B payload, aligned 100 words: 32,32,32,4.
    run_buffer(3'd0, 64'h1000, 32'd100, -1, 1'b0, 1'b0);
    // 256B payload just below a 4KB boundary: 4 then 60.
    run_buffer(3'd1, 64'h0FF0, 32'd64, -1, 1'b0, 1'b0);
    // FIFO holds too few words until raised.
    run_buffer(3'd0, 64'h3000, 32'd20, -1, 1'b1, 1'b0);
    // Abort during the second request (coincident with its ack).
    run_buffer(3'd0, 64'h1000, 32'd100, 1, 1'b0, 1'b0);
    // Abort held during a delayed ack.
    run_buffer(3'd2, 64'h5000, 32'd300, 0, 1'b0, 1'b1);
    // Address carry across bit 32 and 4KB split at 1024B payload.
    run_buffer(3'd3, 64'h0000_0000_FFFF_FF80, 32'd100, -1, 1'b0, 1'b0);
    // Low address bits forced to zero.
    run_buffer(3'd7, 64'h7003, 32'd300, -1, 1'b0, 1'b1);

    // Zero-length buffer: ack and done, no request.
    CONFIG_MAX_PAYLOAD_SIZE = 3'd0;
    BUF_ADDR  = 64'h2000;
    BUF_LEN   = 32'd0;
    BUF_VALID = 1'b1;
    step();
    BUF_VALID = 1'b0;
    check("zero_ack", BUF_ACK, 1);
    check("zero_done", BUF_DONE, 1);
    check("zero_done_len", BUF_DONE_LEN, 0);
    check("zero_no_req", TX_REQ, 0);
    step();
    check("zero_idle", IDLE, 1);
    check("zero_no_req2", TX_REQ, 0);
    $display("zero-length buffer: done_len=%0d", BUF_DONE_LEN);

    // Reset while waiting for TX_SENT; a late TX_SENT must be ignored.
    BUF_ADDR   = 64'h2000;
    BUF_LEN    = 32'd50;
    DATA_AVAIL = 16'hFFFF;
    BUF_VALID  = 1'b1;
    step();
    BUF_VALID = 1'b0;
    step();
    check("rstw_req", TX_REQ, 1);
    TX_REQ_ACK = 1'b1;
    step();
    TX_REQ_ACK = 1'b0;
    RST = 1'b1;
    step();
    RST     = 1'b0;
    TX_SENT = 1'b1;
    step();
    TX_SENT = 1'b0;
    check("rstw_tx_req", TX_REQ, 0);
    check("rstw_tx_addr", TX_ADDR, 0);
    check("rstw_tx_len", TX_LEN, 0);
    check("rstw_buf_ack", BUF_ACK, 0);
    check("rstw_buf_done", BUF_DONE, 0);
    check("rstw_done_len", BUF_DONE_LEN, 0);
    check("rstw_idle", IDLE, 1);
    step();
    check("rstw_no_done_later", BUF_DONE, 0);
    $display("reset in wait: idle=%0d buf_done=%0d", IDLE, BUF_DONE);

    // Randomized buffers, some placed close to 4KB and 4GB boundaries.
    for (int t = 0; t < 8; t++) begin
      ra = {$urandom, $urandom};
      if (t % 3 == 1) ra[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
      if (t % 4 == 2) ra[31:12] = 20'hFFFFF;
      rl = 32'($urandom_range(1, 700));
      run_buffer(3'($urandom_range(0, 7)), ra, rl,
                 (t % 3 == 2) ? int'($urandom_range(0, 2)) : -1,
                 1'(t % 4 == 3), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
